puf_soc_sipo: RTL and testbench
===============================

# puf_soc_sipo

Serial-in/parallel-out deserializer: the receive end of the PUF SoC serial frame link. It accepts a bit stream over a valid/ready handshake, least-significant bit first. It assembles normal (NORM_MOD-bit) or debug (DEBUG_MOD-bit) frames into a FRAM_SIZE-wide parallel word. It presents the completed frame to the downstream consumer through a second valid/ready handshake.

## Interface
- FRAM_SIZE, 160, parallel output width; must satisfy NORM_MOD ≤ FRAM_SIZE and DEBUG_MOD ≤ FRAM_SIZE
- NORM_MOD, 34, data bits per normal frame
- DEBUG_MOD, 133, data bits per debug frame
- clk  input  1  clock
- rst_n  input  1  reset; asynchronous, active-low
- i_rx_en  input  1  1: receiver enabled; 0: pauses bit acceptance, state held
- i_rx_mode  input  1  frame type, 1: debug, 0: normal; sampled on first bit of a frame
- i_rx_flush  input  1  synchronous abort of partial frame
- i_rx_data  input  1  serial data bit
- i_rx_valid  input  1  serial bit valid
- o_rx_ready  output  1  1: receiver accepts a serial bit this cycle
- o_rx_data  output  FRAM_SIZE  assembled frame, bit k = k-th received bit
- o_rx_valid  output  1  1: o_rx_data holds a complete frame
- i_rx_ready  input  1  downstream accepts frame
- o_rx_done  output  1  one-cycle pulse on frame completion
- o_rx_perr  output  1  parity error flag for presented frame

## Operation
- Bit accept: acc = i_rx_en & i_rx_valid & o_rx_ready.
- States: RECV (o_rx_ready=1, o_rx_valid=0) and HOLD (o_rx_ready=0, o_rx_valid=1).
- RECV, on acc: received bit k is written to shift-register index k; bit counter increments.
- First bit of a frame (counter 0): i_rx_mode is latched into the frame length L, with L = DEBUG_MOD if 1, else NORM_MOD. Mode changes mid-frame are ignored.
- Counter width: $clog2(FRAM_SIZE+2).
- On acc of the final bit of the frame (counter = F-1, F = frame bit count): transition to HOLD, set o_rx_valid, pulse o_rx_done, reset counter to 0.
- Register bits at index ≥ L read 0; the register is cleared on entry to RECV.
- HOLD: o_rx_data and o_rx_perr are stable. On i_rx_ready & o_rx_valid, return to RECV; o_rx_valid drops the next cycle.
- i_rx_en low in RECV: no acceptance; counter and partial data held, and the frame resumes when enable returns. o_rx_ready still reflects state only.
- i_rx_flush in RECV: counter and data cleared; any simultaneous acc is discarded. In HOLD, flush is ignored (the frame is never lost).
- i_rx_valid while in HOLD: not accepted; the sender must hold the bit (standard handshake).

## Timing
- Reset values: o_rx_ready=1, o_rx_valid=0, o_rx_done=0, o_rx_perr=0, o_rx_data=0, counter=0, state RECV.
- Bit acceptance: one bit per cycle maximum, with no bubbles inside a frame.
- Completion latency: o_rx_valid, o_rx_done and o_rx_data are all valid the cycle after the edge at which the last bit is accepted.
- Return to RECV: o_rx_ready rises the cycle after the consumer handshake, giving a minimum of one idle serial cycle between frames.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Reset asserted mid-frame: all state returns to reset values immediately and the partial frame is discarded.

## Configuration
- PUF_SOC_SIPO_PARITY_EN defined:
  - Each frame carries one extra trailing bit, so F = L+1.
  - The trailing bit is even parity over the L data bits and is not stored in o_rx_data.
  - o_rx_perr = 1 when the XOR of the L data bits and the parity bit is 1. It is registered with o_rx_valid, held through HOLD, and cleared on return to RECV.
- Undefined: F = L, o_rx_perr is tied to 0, and no parity logic is present.

## Test plan
- Reset, then mode=0 with 34 back-to-back bits of pattern 0x2_A5A5_A5A5 (parity disabled) -> o_rx_valid=1 and o_rx_done pulse one cycle after the 34th bit; o_rx_data=0x2A5A5A5A5 with bits [159:34]=0.
- Mode=1, 133 alternating bits starting at 1, i_rx_ready held 0 for 10 cycles -> o_rx_data stable at 0x…5555 across bits [132:0]; o_rx_ready=0 and extra i_rx_valid bits are not consumed until the handshake.
- Mode toggled to 1 after the 5th bit of a normal frame -> frame still completes after 34 bits.
- i_rx_en dropped for 7 cycles after bit 20 of a 34-bit frame -> counter holds at 20; the frame completes correctly after resumption.
- i_rx_flush asserted after bit 12 -> no o_rx_valid; the next 34 bits form a clean frame. Async rst_n pulse after bit 30 -> all outputs return to reset values within the same cycle.
- With PUF_SOC_SIPO_PARITY_EN, 34 ones followed by parity bit 0 -> o_rx_perr=0. The same frame with parity bit 1 -> o_rx_perr=1; in both cases valid is asserted after 35 bits.

Source files
------------

// File: rtl/puf_soc_sipo_if.sv
// -----------------------------------------------------------------------------
// puf_soc_sipo_if
//
// Bundles the signals of the PUF SoC serial-frame receiver: the serial input
// side, the parallel frame output side, the receiver controls and two debug
// observation signals.
//
// Handshake semantics (both channels): a transfer happens on a rising clk edge
// where valid and ready are both 1. A source that raises valid keeps valid and
// its payload unchanged until that edge. A sink may raise or drop ready
// whenever it likes, and ready does not depend on valid.
//   serial channel : i_rx_valid / o_rx_ready, payload i_rx_data (1 bit)
//   frame channel  : o_rx_valid / i_rx_ready, payload o_rx_data, o_rx_perr
//
// Modports:
//   master - the side that feeds serial bits and consumes frames
//   slave  - the deserializer itself
//
// Signals:
//   i_rx_en     receiver enable (0 pauses bit acceptance, state held)
//   i_rx_mode   frame type, 1: debug, 0: normal (taken on first bit of a frame)
//   i_rx_flush  synchronous abort of a partial frame
//   i_rx_data   serial data bit, LSB of the frame first
//   i_rx_valid  serial bit valid
//   o_rx_ready  receiver accepts a serial bit this cycle
//   o_rx_data   assembled frame, bit k = k-th received bit
//   o_rx_valid  o_rx_data holds a complete frame
//   i_rx_ready  downstream accepts the frame
//   o_rx_done   one-cycle pulse on frame completion
//   o_rx_perr   parity error flag of the presented frame
//   dbg_state   receiver FSM state (0: RECV, 1: HOLD)
//   dbg_cnt     received-bit counter of the frame in progress
// -----------------------------------------------------------------------------
interface puf_soc_sipo_if #(
  parameter int FRAM_SIZE = 160,
  parameter int CNT_W     = $clog2(FRAM_SIZE + 2)
);

  logic                 i_rx_en;
  logic                 i_rx_mode;
  logic                 i_rx_flush;
  logic                 i_rx_data;
  logic                 i_rx_valid;
  logic                 o_rx_ready;
  logic [FRAM_SIZE-1:0] o_rx_data;
  logic                 o_rx_valid;
  logic                 i_rx_ready;
  logic                 o_rx_done;
  logic                 o_rx_perr;
  logic                 dbg_state;
  logic [CNT_W-1:0]     dbg_cnt;

  modport master (
    output i_rx_en,
    output i_rx_mode,
    output i_rx_flush,
    output i_rx_data,
    output i_rx_valid,
    input  o_rx_ready,
    input  o_rx_data,
    input  o_rx_valid,
    output i_rx_ready,
    input  o_rx_done,
    input  o_rx_perr,
    input  dbg_state,
    input  dbg_cnt
  );

  modport slave (
    input  i_rx_en,
    input  i_rx_mode,
    input  i_rx_flush,
    input  i_rx_data,
    input  i_rx_valid,
    output o_rx_ready,
    output o_rx_data,
    output o_rx_valid,
    input  i_rx_ready,
    output o_rx_done,
    output o_rx_perr,
    output dbg_state,
    output dbg_cnt
  );

endinterface

// File: rtl/puf_soc_sipo.sv
// -----------------------------------------------------------------------------
// puf_soc_sipo
//
// Serial-in/parallel-out deserializer at the receive end of the PUF SoC serial
// frame link. Serial bits arrive LSB first over a valid/ready handshake and
// are assembled into a FRAM_SIZE-wide word. A frame is either NORM_MOD bits
// (normal) or DEBUG_MOD bits (debug); the type is taken from i_rx_mode on the
// first bit of each frame. The finished frame is offered downstream over a
// second valid/ready handshake and held until it is taken.
//
// Optional feature (compile-time macro PUF_SOC_SIPO_PARITY_EN):
//   defined   - each frame carries one trailing even-parity bit after its data
//               bits; it is not stored, and o_rx_perr reports a mismatch.
//   undefined - frames carry data bits only and o_rx_perr is tied to 0.
//
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset
//   rx     puf_soc_sipo_if.slave (serial input, frame output, controls, debug)
//
// Parameters:
//   FRAM_SIZE  parallel output width (>= NORM_MOD and >= DEBUG_MOD)
//   NORM_MOD   data bits per normal frame
//   DEBUG_MOD  data bits per debug frame
//
// FSM:
//   RECV - o_rx_ready=1, shifting in bits
//   HOLD - o_rx_valid=1, frame presented and frozen until consumed
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module puf_soc_sipo #(
  parameter int FRAM_SIZE = 160,
  parameter int NORM_MOD  = 34,
  parameter int DEBUG_MOD = 133
) (
  input  logic            clk,
  input  logic            rst_n,
  puf_soc_sipo_if.slave   rx
);

  localparam int CNT_W = $clog2(FRAM_SIZE + 2);

`ifdef PUF_SOC_SIPO_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  // Counter value at which the final bit of each frame type is accepted.
  localparam logic [CNT_W-1:0] NORM_LAST = CNT_W'(NORM_MOD + PAR_BITS - 1);
  localparam logic [CNT_W-1:0] DBG_LAST  = CNT_W'(DEBUG_MOD + PAR_BITS - 1);

  typedef enum logic {
    RECV = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 mode_q;
  logic [FRAM_SIZE-1:0] data_q;
  logic                 ready_q;
  logic                 valid_q;
  logic                 done_q;

  logic                 acc;
  logic                 frame_dbg;
  logic                 last_bit;
  logic                 store_bit;
  logic [FRAM_SIZE-1:0] bit_set;

  assign acc = rx.i_rx_en & rx.i_rx_valid & ready_q;

  // The frame type is live from i_rx_mode only on the first bit; afterwards
  // the latched copy is used, so mode changes mid-frame have no effect.
  assign frame_dbg = (cnt_q == '0) ? rx.i_rx_mode : mode_q;
  assign last_bit  = (cnt_q == (frame_dbg ? DBG_LAST : NORM_LAST));

  // One-hot of the incoming bit at its frame position. Bits above the frame
  // length are never set because the counter never reaches them.
  assign bit_set = {{(FRAM_SIZE-1){1'b0}}, rx.i_rx_data} << cnt_q;

`ifdef PUF_SOC_SIPO_PARITY_EN
  logic par_q;
  logic perr_q;

  // The parity bit is the last bit of the frame and is not stored.
  assign store_bit = ~last_bit;
`else
  assign store_bit = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RECV;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      data_q  <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
`ifdef PUF_SOC_SIPO_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        RECV: begin
          if (rx.i_rx_flush) begin
            // Abort wins over a bit accepted in the same cycle.
            cnt_q  <= '0;
            data_q <= '0;
`ifdef PUF_SOC_SIPO_PARITY_EN
            par_q  <= 1'b0;
`endif
          end else if (acc) begin
            if (cnt_q == '0) begin
              mode_q <= rx.i_rx_mode;
            end
            if (store_bit) begin
              data_q <= data_q | bit_set;
            end
            if (last_bit) begin
              state_q <= HOLD;
              cnt_q   <= '0;
              ready_q <= 1'b0;
              valid_q <= 1'b1;
              done_q  <= 1'b1;
`ifdef PUF_SOC_SIPO_PARITY_EN
              // Running XOR of data bits folded with the parity bit itself.
              perr_q  <= par_q ^ rx.i_rx_data;
              par_q   <= 1'b0;
`endif
            end else begin
              cnt_q <= cnt_q + 1'b1;
`ifdef PUF_SOC_SIPO_PARITY_EN
              par_q <= par_q ^ rx.i_rx_data;
`endif
            end
          end
        end

        HOLD: begin
          // Flush is ignored here: a completed frame is always delivered.
          if (rx.i_rx_ready) begin
            state_q <= RECV;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            data_q  <= '0;
`ifdef PUF_SOC_SIPO_PARITY_EN
            perr_q  <= 1'b0;
`endif
          end
        end

        default: begin
          state_q <= RECV;
          cnt_q   <= '0;
          data_q  <= '0;
          ready_q <= 1'b1;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign rx.o_rx_ready = ready_q;
  assign rx.o_rx_valid = valid_q;
  assign rx.o_rx_data  = data_q;
  assign rx.o_rx_done  = done_q;
  assign rx.dbg_state  = state_q;
  assign rx.dbg_cnt    = cnt_q;

`ifdef PUF_SOC_SIPO_PARITY_EN
  assign rx.o_rx_perr = perr_q;
`else
  assign rx.o_rx_perr = 1'b0;
`endif

`ifndef SYNTHESIS
  // Ready and valid mirror the two states and are never both set.
  a_ready_is_recv : assert property (@(posedge clk) disable iff (!rst_n)
    ready_q == (state_q == RECV));
  a_ready_valid_excl : assert property (@(posedge clk) disable iff (!rst_n)
    ready_q != valid_q);
  a_done_with_valid : assert property (@(posedge clk) disable iff (!rst_n)
    done_q |-> valid_q);
  a_cnt_in_frame : assert property (@(posedge clk) disable iff (!rst_n)
    cnt_q <= DBG_LAST || cnt_q <= NORM_LAST);
`endif

endmodule

// File: tb/tb_puf_soc_sipo.sv
// -----------------------------------------------------------------------------
// tb_puf_soc_sipo
//
// Bench for puf_soc_sipo. Inputs are driven on the falling edge and outputs
// are sampled on the falling edge, away from the active rising edge.
// Build with +define+PUF_SOC_SIPO_PARITY_EN to exercise the parity variant.
// -----------------------------------------------------------------------------
module tb_puf_soc_sipo;

  localparam int FW   = 160;
  localparam int NORM = 34;
  localparam int DBG  = 133;
`ifdef PUF_SOC_SIPO_PARITY_EN
  localparam int PAR  = 1;
`else
  localparam int PAR  = 0;
`endif

  // ---------------------------------------------------------------- clock/reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  puf_soc_sipo_if #(.FRAM_SIZE(FW)) bus ();

  puf_soc_sipo #(
    .FRAM_SIZE (FW),
    .NORM_MOD  (NORM),
    .DEBUG_MOD (DBG)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rx    (bus)
  );

  // ---------------------------------------------------------------- scoreboard
  int n_tests = 0;
  int n_fail  = 0;
  logic [FW-1:0] exp_q[$];
  logic          perr_q[$];

  task automatic check(input string name, input logic [FW-1:0] act,
                       input logic [FW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: a frame keeps the first L stream bits, everything above
  // is zero; perr is the XOR of those bits and the parity bit (parity build).
  function automatic int frame_len(input logic mode);
    return mode ? DBG : NORM;
  endfunction

  function automatic logic [FW-1:0] model_frame(input logic [FW-1:0] s,
                                                input logic mode);
    logic [FW-1:0] r = '0;
    for (int k = 0; k < frame_len(mode); k++) r[k] = s[k];
    return r;
  endfunction

  function automatic logic model_perr(input logic [FW-1:0] s, input logic mode,
                                      input logic pbit);
    int ones = 0;
    for (int k = 0; k < frame_len(mode); k++) ones += int'(s[k]);
    if (PAR == 0) return 1'b0;
    return logic'((ones + int'(pbit)) % 2);
  endfunction

  // ---------------------------------------------------------------- drivers
  // Sends nbits serial bits; the bit at position i is stream[i] for data bits
  // and pbit after them. Returns just after the edge accepting the last bit.
  task automatic send_frame(input logic [FW-1:0] s, input logic mode,
                            input logic pbit, input int nbits,
                            input int toggle_at, input int pause_at,
                            input bit rand_gaps);
    int  i      = 0;
    int  guard  = 0;
    bit  paused = 0;
    bit  rdy;
    logic b;
    while (i < nbits && guard < 4000) begin
      @(negedge clk);
      b = (i < frame_len(mode)) ? s[i] : pbit;
      if (i == pause_at && !paused) begin
        paused = 1;
        bus.i_rx_en    = 1'b0;
        bus.i_rx_valid = 1'b1;
        bus.i_rx_data  = b;
        repeat (7) @(negedge clk);
        check("pause_cnt",   bus.dbg_cnt,    pause_at);
        check("pause_ready", bus.o_rx_ready, 1'b1);
        check("pause_valid", bus.o_rx_valid, 1'b0);
        bus.i_rx_en = 1'b1;
      end
      bus.i_rx_valid = (rand_gaps && $urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
      bus.i_rx_en    = (rand_gaps && $urandom_range(0, 7) == 0) ? 1'b0 : 1'b1;
      bus.i_rx_data  = b;
      bus.i_rx_mode  = (toggle_at >= 0 && i >= toggle_at) ? ~mode : mode;
      rdy = bus.o_rx_ready & bus.i_rx_valid & bus.i_rx_en;
      @(posedge clk);
      if (rdy) i++;
      guard++;
    end
    bus.i_rx_en = 1'b1;
    if (guard >= 4000) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: got %0d bits expected %0d", i, nbits);
    end
  endtask

  // Checks the frame presented after the last bit, holds it for hold_cycles,
  // then consumes it and checks the return to RECV.
  task automatic expect_frame(input string tag, input int hold_cycles);
    logic [FW-1:0] ed;
    logic          ep;
    ed = exp_q.pop_front();
    ep = perr_q.pop_front();
    @(negedge clk);
    bus.i_rx_valid = 1'b0;
    check({tag, "_valid"}, bus.o_rx_valid, 1'b1);
    check({tag, "_done"},  bus.o_rx_done,  1'b1);
    check({tag, "_ready"}, bus.o_rx_ready, 1'b0);
    check({tag, "_data"},  bus.o_rx_data,  ed);
    check({tag, "_perr"},  bus.o_rx_perr,  ep);
    for (int c = 0; c < hold_cycles; c++) begin
      @(negedge clk);
      check({tag, "_hold_done"}, bus.o_rx_done, 1'b0);
      check({tag, "_hold_data"}, bus.o_rx_data, ed);
      check({tag, "_hold_perr"}, bus.o_rx_perr, ep);
    end
    bus.i_rx_ready = 1'b1;
    @(negedge clk);
    bus.i_rx_ready = 1'b0;
    check({tag, "_ret_valid"}, bus.o_rx_valid, 1'b0);
    check({tag, "_ret_ready"}, bus.o_rx_ready, 1'b1);
    check({tag, "_ret_data"},  bus.o_rx_data,  '0);
    check({tag, "_ret_perr"},  bus.o_rx_perr,  1'b0);
  endtask

  task automatic push_exp(input logic [FW-1:0] d, input logic p);
    exp_q.push_back(d);
    perr_q.push_back(p);
  endtask

  // ---------------------------------------------------------------- vectors
  typedef struct {
    logic          mode;
    logic [FW-1:0] stream;
    logic          pbit;
    logic [FW-1:0] exp_data;
    logic          exp_perr;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [FW-1:0] alt;
    logic [FW-1:0] ones;
    logic [FW-1:0] tmp;
    logic          m;
    logic          pb;
    logic          perr_bad;

    perr_bad = (PAR != 0);
    alt  = {40{4'h5}};
    ones = '1;
    vecs[0] = '{1'b0, 160'h2_A5A5_A5A5, 1'b1, 160'h2_A5A5_A5A5, 1'b0};
    vecs[1] = '{1'b1, alt, 1'b1, {27'b0, 1'b1, {33{4'h5}}}, 1'b0};
    vecs[2] = '{1'b0, ones, 1'b0, {126'b0, {34{1'b1}}}, 1'b0};
    vecs[3] = '{1'b0, ones, 1'b1, {126'b0, {34{1'b1}}}, perr_bad};
    vecs[4] = '{1'b1, ones, 1'b1, {27'b0, {133{1'b1}}}, 1'b0};
    vecs[5] = '{1'b0, '0, 1'b1, '0, perr_bad};
    vecs[6] = '{1'b1, 160'h1 << 132, 1'b1, 160'h1 << 132, 1'b0};
    vecs[7] = '{1'b0, {{126{1'b1}}, 34'h2_0000_0001}, 1'b0, 160'h2_0000_0001, 1'b0};

    bus.i_rx_en    = 1'b1;
    bus.i_rx_mode  = 1'b0;
    bus.i_rx_flush = 1'b0;
    bus.i_rx_data  = 1'b0;
    bus.i_rx_valid = 1'b0;
    bus.i_rx_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ready", bus.o_rx_ready, 1'b1);
    check("rst_valid", bus.o_rx_valid, 1'b0);
    check("rst_done",  bus.o_rx_done,  1'b0);
    check("rst_perr",  bus.o_rx_perr,  1'b0);
    check("rst_data",  bus.o_rx_data,  '0);
    check("rst_cnt",   bus.dbg_cnt,    '0);
    check("rst_state", bus.dbg_state,  1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven frames
    for (int v = 0; v < 8; v++) begin
      push_exp(vecs[v].exp_data, vecs[v].exp_perr);
      send_frame(vecs[v].stream, vecs[v].mode, vecs[v].pbit,
                 frame_len(vecs[v].mode) + PAR, -1, -1, 1'b0);
      expect_frame($sformatf("vec%0d", v), v % 3);
    end

    // Debug frame held by the consumer with extra bits offered meanwhile
    push_exp(vecs[1].exp_data, 1'b0);
    send_frame(alt, 1'b1, 1'b1, DBG + PAR, -1, -1, 1'b0);
    @(negedge clk);
    check("hold_valid", bus.o_rx_valid, 1'b1);
    check("hold_data0", bus.o_rx_data, exp_q[0]);
    bus.i_rx_valid = 1'b1;
    bus.i_rx_data  = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("hold_ready", bus.o_rx_ready, 1'b0);
      check("hold_data",  bus.o_rx_data,  exp_q[0]);
      check("hold_cnt",   bus.dbg_cnt,    '0);
    end
    bus.i_rx_valid = 1'b0;
    bus.i_rx_ready = 1'b1;
    @(negedge clk);
    bus.i_rx_ready = 1'b0;
    void'(exp_q.pop_front());
    void'(perr_q.pop_front());
    check("hold_ret_cnt",   bus.dbg_cnt,    '0);
    check("hold_ret_ready", bus.o_rx_ready, 1'b1);
    push_exp(160'h2_A5A5_A5A5, 1'b0);
    send_frame(160'h2_A5A5_A5A5, 1'b0, 1'b1, NORM + PAR, -1, -1, 1'b0);
    expect_frame("after_hold", 0);

    // Mode raised after the 5th bit of a normal frame
    push_exp(model_frame(alt, 1'b0), model_perr(alt, 1'b0, 1'b0));
    send_frame(alt, 1'b0, 1'b0, NORM + PAR, 5, -1, 1'b0);
    expect_frame("mode_toggle", 1);

    // Enable dropped for 7 cycles after bit 20
    push_exp(vecs[0].exp_data, 1'b0);
    send_frame(160'h2_A5A5_A5A5, 1'b0, 1'b1, NORM + PAR, -1, 20, 1'b0);
    expect_frame("en_pause", 0);

    // Flush after bit 12, with a bit offered in the same cycle
    send_frame(ones, 1'b0, 1'b0, 12, -1, -1, 1'b0);
    @(negedge clk);
    check("flush_pre_cnt", bus.dbg_cnt, 12);
    bus.i_rx_flush = 1'b1;
    bus.i_rx_valid = 1'b1;
    bus.i_rx_data  = 1'b1;
    @(negedge clk);
    bus.i_rx_flush = 1'b0;
    bus.i_rx_valid = 1'b0;
    check("flush_cnt",   bus.dbg_cnt,    '0);
    check("flush_data",  bus.o_rx_data,  '0);
    check("flush_valid", bus.o_rx_valid, 1'b0);
    push_exp(vecs[7].exp_data, 1'b0);
    send_frame(vecs[7].stream, 1'b0, 1'b0, NORM + PAR, -1, -1, 1'b0);
    expect_frame("post_flush", 0);

    // Asynchronous reset after bit 30
    send_frame(ones, 1'b0, 1'b0, 30, -1, -1, 1'b0);
    @(negedge clk);
    bus.i_rx_valid = 1'b0;
    check("arst_pre_cnt",  bus.dbg_cnt,   30);
    check("arst_pre_data", bus.o_rx_data, {130'b0, {30{1'b1}}});
    #2 rst_n = 1'b0;
    #1;
    check("arst_ready", bus.o_rx_ready, 1'b1);
    check("arst_valid", bus.o_rx_valid, 1'b0);
    check("arst_done",  bus.o_rx_done,  1'b0);
    check("arst_perr",  bus.o_rx_perr,  1'b0);
    check("arst_data",  bus.o_rx_data,  '0);
    check("arst_cnt",   bus.dbg_cnt,    '0);
    @(negedge clk);
    rst_n = 1'b1;
    push_exp(vecs[0].exp_data, 1'b0);
    send_frame(160'h2_A5A5_A5A5, 1'b0, 1'b1, NORM + PAR, -1, -1, 1'b0);
    expect_frame("post_arst", 0);

`ifdef PUF_SOC_SIPO_PARITY_EN
    // 34 ones with correct and with wrong parity bit
    push_exp({126'b0, {34{1'b1}}}, 1'b0);
    send_frame(ones, 1'b0, 1'b0, 35, -1, -1, 1'b0);
    expect_frame("par_ok", 0);
    push_exp({126'b0, {34{1'b1}}}, 1'b1);
    send_frame(ones, 1'b0, 1'b1, 35, -1, -1, 1'b0);
    expect_frame("par_bad", 0);
`endif

    // Randomized frames against the model
    for (int r = 0; r < 30; r++) begin
      tmp = {$urandom, $urandom, $urandom, $urandom, $urandom};
      m   = logic'($urandom_range(0, 1));
      pb  = logic'($urandom_range(0, 1));
      push_exp(model_frame(tmp, m), model_perr(tmp, m, pb));
      send_frame(tmp, m, pb, frame_len(m) + PAR,
                 ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 30)) : -1,
                 -1, 1'b1);
      expect_frame($sformatf("rnd%0d", r), $urandom_range(0, 4));
    end

    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_empty: got %0d entries expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Bound on the whole run
  initial begin
    #500000;
    n_tests++;
    n_fail++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
